// File: rtl/pipeline_stage_buf_if.sv
// Handshake bundle between an upstream stage, the pipeline buffer and the downstream stage.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both high; valid, once raised, holds its payload until that edge.
interface pipeline_stage_buf_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] d_data;
    logic              d_valid;
    logic              d_ready;
    logic [DATA_W-1:0] q_data;
    logic              q_valid;
    logic              q_ready;

    // Environment side: produces upstream beats and consumes downstream beats.
    modport master (
        output d_data,
        output d_valid,
        output q_ready,
        input  d_ready,
        input  q_data,
        input  q_valid
    );

    modport slave (
        input  d_data,
        input  d_valid,
        input  q_ready,
        output d_ready,
        output q_data,
        output q_valid
    );
endinterface

// File: rtl/pipeline_stage_buf.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush-to-NOP, a delayed
// PC-increment sideband and a saturating bubble counter.
module pipeline_stage_buf #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stage_buf_if.slave  bus,
    input  logic                 flush,
    input  logic                 d_pcincr,
    output logic                 qd_pcincr,
    input  logic                 bubble_clr,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              q_valid_q, q_valid_d;
    logic              d_ready_q, d_ready_d;
    logic              pcincr_q;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              push;
    logic              pop;

    // Handshake flags come straight from registers, so q_ready never reaches d_ready.
    assign push = bus.d_valid & d_ready_q;
    assign pop  = q_valid_q & bus.q_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = HALF;
                        main_d  = bus.d_data;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        main_d = bus.d_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = bus.d_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = HALF;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
        q_valid_d = (state_d != EMPTY);
        d_ready_d = (state_d != FULL);
    end

    always_comb begin
        bubble_d = bubble_q;
        if (bubble_clr) begin
            bubble_d = '0;
        end else if (bus.q_ready && !q_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= EMPTY;
            main_q    <= NOP_VALUE;
            skid_q    <= NOP_VALUE;
            q_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            pcincr_q  <= 1'b0;
            bubble_q  <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            q_valid_q <= q_valid_d;
            d_ready_q <= d_ready_d;
            pcincr_q  <= d_pcincr;
            bubble_q  <= bubble_d;
        end
    end

    assign bus.q_data  = main_q;
    assign bus.q_valid = q_valid_q;
    assign bus.d_ready = d_ready_q;
    assign qd_pcincr   = pcincr_q;
    assign bubble_cnt  = bubble_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/pipeline_stage_buf.md
Name: pipeline_stage_buf

Overview:
Parametrised inter-stage pipeline register that generalises the fixed decode->execute latch. It carries an arbitrary-width packed payload between two pipeline stages using a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction. It also supports flush with clean NOP insertion, a registered PC-increment sideband, and a saturating bubble counter for pipeline-efficiency measurement.

Parameters:
DATA_W, 64, payload width in bits (packed operands and control fields).
NOP_VALUE, {DATA_W{1'b0}}, payload driven on q_data whenever the stage holds no valid entry.
CNT_W, 16, bubble counter width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-low; sampled on rising clk edge.
d_data  input  DATA_W  upstream payload.
d_valid  input  1  upstream payload valid.
d_ready  output  1  stage can accept; high when skid entry is empty.
q_data  output  DATA_W  downstream payload (main entry).
q_valid  output  1  main entry valid.
q_ready  input  1  downstream accepts.
flush  input  1  discard all held and incoming entries.
d_pcincr  input  1  PC-increment request sideband.
qd_pcincr  output  1  d_pcincr delayed one cycle.
bubble_clr  input  1  clear bubble counter.
bubble_cnt  output  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst==0 at edge): state EMPTY; main, skid <= NOP_VALUE; q_valid=0, d_ready=1, qd_pcincr=0, bubble_cnt=0. Reset overrides all other inputs.
- push = d_valid & d_ready; pop = q_valid & q_ready.
- States: EMPTY (no entry), HALF (main valid), FULL (main + skid valid). q_valid = (state != EMPTY); d_ready = (state != FULL), decoded from state registers only, no combinational path from q_ready.
- EMPTY: push -> HALF, main <= d_data.
- HALF: push&pop -> HALF, main <= d_data; push&!pop -> FULL, skid <= d_data; !push&pop -> EMPTY, main <= NOP_VALUE; neither -> hold.
- FULL: pop -> HALF, main <= skid, skid <= NOP_VALUE; else hold. No push possible.
- Invariant: q_valid==0 implies q_data==NOP_VALUE; order preserved; no loss or duplication.
- Latency: accepted input visible on q_data/q_valid next cycle; sustained throughput 1 entry/cycle when q_ready=1.
- flush (rst inactive): next state EMPTY, main, skid <= NOP_VALUE regardless of state, push or pop; the same-cycle input is dropped even if d_ready was high. A same-cycle pop is still counted as consumed by downstream.
- qd_pcincr <= d_pcincr every cycle; unaffected by flush; cleared only by reset.
- bubble_cnt: bubble_clr has priority -> 0; else +1 when q_ready & !q_valid; saturates at 2^CNT_W-1, no wrap.

Test Plan:
- Reset with d_valid=1, d_data=0xAA, rst=0 for 2 cycles -> q_valid=0, q_data=NOP_VALUE, d_ready=1, qd_pcincr=0, bubble_cnt=0.
- Streaming, q_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> q_data 0x11,0x22,0x33 one cycle later each, d_ready stays 1.
- Back-pressure: q_ready=0, push A,B -> d_ready=0 after B, C held upstream; raise q_ready -> output A,B,C in order, each exactly once.
- Flush in FULL with d_valid=1, d_data=0x44 -> next cycle q_valid=0, q_data=NOP_VALUE, d_ready=1; 0x44 never appears.
- CNT_W=4, idle 20 cycles with q_ready=1 -> bubble_cnt=15 (saturated); pulse bubble_clr -> 0 next cycle.
- rst=0 asserted while FULL, q_ready=1 -> next cycle EMPTY, q_valid=0, no entry emitted.
